// File: rtl/controle_busca.sv
// Fetch/sequencing controller: owns the PC, latches instructions into ir,
// resolves control flow and issues per-instruction strobes to the datapath.
module controle_busca #(
    parameter int unsigned TAM_MEM = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [31:0] Instrucao,
    input  logic        igual,
    input  logic        entrada_ok,
    output logic [31:0] Endereco,
    output logic [31:0] ir,
    output logic [31:0] pc_mais_um,
    output logic        escreve_reg,
    output logic        escreve_mem,
    output logic        saida_valida,
    output logic        esperando_entrada,
    output logic        parado,
    output logic        erro,
    output logic [2:0]  estado
);

    localparam int unsigned PC_W = (TAM_MEM > 1) ? $clog2(TAM_MEM) : 1;

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        BUSCA          = 3'd1,
        EXECUTA        = 3'd2,
        ESPERA_ENTRADA = 3'd3,
        PARADO         = 3'd4
    } estado_t;

    estado_t         estado_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    logic            erro_q;

    logic [4:0]      op;
    logic [31:0]     alvo;
    logic            ilegal;
    logic            vai_espera;
    logic            avanca;
    logic            fora;

    assign op         = ir_q[31:27];
    assign Endereco   = 32'(pc_q);
    assign pc_mais_um = 32'(pc_q) + 32'd1;
    assign ir         = ir_q;
    assign erro       = erro_q;
    assign estado     = estado_q;
    assign parado            = (estado_q == PARADO);
    assign esperando_entrada = (estado_q == ESPERA_ENTRADA);

    // Decode: strobes, candidate next PC and the kind of transition
    always_comb begin
        escreve_reg  = 1'b0;
        escreve_mem  = 1'b0;
        saida_valida = 1'b0;
        alvo         = pc_mais_um;
        ilegal       = 1'b0;
        vai_espera   = 1'b0;
        avanca       = 1'b0;
        unique case (estado_q)
            EXECUTA: begin
                avanca = 1'b1;
                if (!op[4]) begin
                    if (op == 5'b00110) escreve_mem = 1'b1;
                    else                escreve_reg = 1'b1;
                end else if (op[3]) begin
                    ilegal = 1'b1;
                    avanca = 1'b0;
                end else begin
                    case (op[2:0])
                        3'b000: begin
                        end
                        3'b001: escreve_reg = 1'b1;
                        3'b010: alvo = 32'(ir_q[26:18]);
                        3'b011: begin
                            escreve_reg = 1'b1;
                            alvo        = 32'(ir_q[17:9]);
                        end
                        3'b101: begin
                            if (igual) alvo = 32'(ir_q[26:18]);
                        end
                        3'b110: begin
                            vai_espera = 1'b1;
                            avanca     = 1'b0;
                        end
                        3'b111: saida_valida = 1'b1;
                        default: begin
                            ilegal = 1'b1;
                            avanca = 1'b0;
                        end
                    endcase
                end
            end
            ESPERA_ENTRADA: begin
                if (entrada_ok) begin
                    escreve_reg = 1'b1;
                    avanca      = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Targets are compared at full width so wide jump fields cannot alias into range
    assign fora = (alvo >= 32'(TAM_MEM));

    // State, PC, instruction register and sticky error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            pc_q     <= '0;
            ir_q     <= '0;
            erro_q   <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) estado_q <= BUSCA;
                end
                BUSCA: begin
                    ir_q     <= Instrucao;
                    estado_q <= EXECUTA;
                end
                EXECUTA, ESPERA_ENTRADA: begin
                    if (ilegal || (avanca && fora)) begin
                        erro_q   <= 1'b1;
                        estado_q <= PARADO;
                    end else if (vai_espera) begin
                        estado_q <= ESPERA_ENTRADA;
                    end else if (avanca) begin
                        pc_q     <= alvo[PC_W-1:0];
                        estado_q <= BUSCA;
                    end
                end
                PARADO: begin
                    if (iniciar) begin
                        pc_q     <= '0;
                        erro_q   <= 1'b0;
                        estado_q <= BUSCA;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_busca.sv
// Bench for controle_busca: directed programs plus random programs, checked
// cycle by cycle against an instruction-level reference model.
module tb_controle_busca;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic [31:0] Instrucao;
    logic        igual;
    logic        entrada_ok;
    logic [31:0] Endereco;
    logic [31:0] ir;
    logic [31:0] pc_mais_um;
    logic        escreve_reg;
    logic        escreve_mem;
    logic        saida_valida;
    logic        esperando_entrada;
    logic        parado;
    logic        erro;
    logic [2:0]  estado;

    logic [31:0] mem [64];

    int n_cmp;
    int n_err;

    // Reference model state: phase 0 idle, 1 fetch, 2 execute, 3 wait input, 4 halted
    int          m_est;
    int          m_pc;
    bit          m_erro;
    logic [31:0] m_ir;

    controle_busca #(.TAM_MEM(64)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .Instrucao(Instrucao),
        .igual(igual), .entrada_ok(entrada_ok), .Endereco(Endereco), .ir(ir),
        .pc_mais_um(pc_mais_um), .escreve_reg(escreve_reg), .escreve_mem(escreve_mem),
        .saida_valida(saida_valida), .esperando_entrada(esperando_entrada),
        .parado(parado), .erro(erro), .estado(estado)
    );

    assign Instrucao = mem[Endereco[5:0]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input int op, input int a, input int b);
        return {5'(op), 9'(a), 9'(b), 9'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction
    function automatic void efeito(input logic [31:0] ins, input int pc, input bit ig,
                                   output int prox, output bit wr, output bit wm,
                                   output bit sv, output bit ilg, output bit esp);
        int op;
        op   = int'(ins[31:27]);
        prox = pc + 1;
        wr = 0; wm = 0; sv = 0; ilg = 0; esp = 0;
        if (op <= 15) begin
            if (op == 6) wm = 1;
            else         wr = 1;
        end else begin
            case (op)
                16: begin end
                17: wr = 1;
                18: prox = int'(ins[26:18]);
                19: begin wr = 1; prox = int'(ins[17:9]); end
                21: if (ig) prox = int'(ins[26:18]);
                22: begin esp = 1; prox = pc; end
                23: sv = 1;
                default: ilg = 1;
            endcase
        end
    endfunction

    task automatic ciclo(input bit ini, input bit ig, input bit ok);
        int prox;
        bit wr, wm, sv, ilg, esp;
        iniciar = ini; igual = ig; entrada_ok = ok;
        #1;
        prox = m_pc + 1;
        wr = 0; wm = 0; sv = 0; ilg = 0; esp = 0;
        if (m_est == 2) efeito(m_ir, m_pc, ig, prox, wr, wm, sv, ilg, esp);
        else if (m_est == 3 && ok) wr = 1;
        chk("estado", 32'(estado), 32'(m_est));
        chk("Endereco", Endereco, 32'(m_pc));
        chk("pc_mais_um", pc_mais_um, 32'(m_pc + 1));
        chk("ir", ir, m_ir);
        chk("escreve_reg", 32'(escreve_reg), 32'(wr));
        chk("escreve_mem", 32'(escreve_mem), 32'(wm));
        chk("saida_valida", 32'(saida_valida), 32'(sv));
        chk("parado", 32'(parado), 32'(m_est == 4));
        chk("esperando", 32'(esperando_entrada), 32'(m_est == 3));
        chk("erro", 32'(erro), 32'(m_erro));
        case (m_est)
            0: if (ini) m_est = 1;
            1: begin m_ir = mem[m_pc]; m_est = 2; end
            2: begin
                if (ilg || (!esp && prox >= 64)) begin m_erro = 1; m_est = 4; end
                else if (esp) m_est = 3;
                else begin m_pc = prox; m_est = 1; end
            end
            3: if (ok) begin
                if (m_pc + 1 >= 64) begin m_erro = 1; m_est = 4; end
                else begin m_pc = m_pc + 1; m_est = 1; end
            end
            default: if (ini) begin m_pc = 0; m_erro = 0; m_est = 1; end
        endcase
        @(negedge clock);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge
    task automatic aplica_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_Endereco", Endereco, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_strobes", 32'({escreve_reg, escreve_mem, saida_valida}), 32'd0);
        chk("rst_flags", 32'({parado, esperando_entrada}), 32'd0);
        m_est = 0; m_pc = 0; m_erro = 0; m_ir = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic enche_nop();
        for (int i = 0; i < 64; i++) mem[i] = enc(16, 0, 0);
    endtask

    task automatic roda(input int n, input bit ig);
        for (int i = 0; i < n; i++) ciclo(0, ig, 0);
    endtask

    task automatic partida();
        ciclo(0, 0, 0);
        ciclo(1, 0, 0);
    endtask

    function automatic logic [31:0] instr_aleatoria();
        int s, op, a, b;
        s = int'($urandom_range(0, 19));
        a = int'($urandom_range(0, 63));
        b = int'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0) a = int'($urandom_range(64, 511));
        if ($urandom_range(0, 9) == 0) b = int'($urandom_range(64, 511));
        case (s)
            0, 1, 2, 3, 4, 5: op = int'($urandom_range(0, 15));
            6:  op = 16;
            7:  op = 17;
            8, 9: op = 18;
            10: op = 19;
            11, 12: op = 21;
            13, 14: op = 22;
            15, 16: op = 23;
            17: op = 20;
            18: op = int'($urandom_range(24, 31));
            default: op = 6;
        endcase
        return enc(op, a, b);
    endfunction

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0; iniciar = 1'b0; igual = 1'b0; entrada_ok = 1'b0;
        enche_nop();
        aplica_reset();

        // Plain nops: 2-cycle fetch/execute rhythm, no strobes
        partida();
        roda(8, 0);

        // li, add, out
        enche_nop();
        mem[0] = enc(1, 3, 0); mem[1] = enc(2, 4, 3); mem[2] = enc(23, 4, 0);
        aplica_reset(); partida(); roda(10, 0);

        // beq not taken, sequential run into jump back to beq
        enche_nop();
        mem[2] = enc(21, 10, 0); mem[9] = enc(18, 2, 0);
        aplica_reset(); partida(); roda(24, 0);
        // beq taken
        aplica_reset(); partida(); roda(8, 1);

        // jal link and target
        enche_nop();
        mem[0] = enc(18, 31, 0); mem[31] = enc(19, 18, 33);
        aplica_reset(); partida(); roda(8, 0);

        // in: long wait with ignored iniciar/igual, then confirm
        enche_nop();
        mem[5] = enc(22, 7, 0);
        aplica_reset(); partida(); roda(12, 0);
        for (int i = 0; i < 20; i++) ciclo(i[0], 1, 0);
        ciclo(0, 0, 1);
        roda(4, 0);
        // reset during the wait
        aplica_reset(); partida(); roda(14, 0);
        aplica_reset();

        // Illegal opcodes halt; iniciar restarts and clears erro
        enche_nop();
        mem[4] = enc(31, 0, 0);
        partida(); roda(12, 0);
        roda(3, 0);
        ciclo(1, 0, 0);
        roda(3, 0);
        mem[4] = enc(20, 0, 0);
        aplica_reset(); partida(); roda(14, 0);

        // Out-of-range PC: sequential wrap at 63 and wide jump target
        enche_nop();
        mem[0] = enc(18, 63, 0);
        aplica_reset(); partida(); roda(8, 0);
        mem[0] = enc(18, 100, 0);
        aplica_reset(); partida(); roda(5, 0);
        // Jump to self is a loop, not a halt
        mem[0] = enc(18, 0, 0);
        aplica_reset(); partida(); roda(8, 0);

        // Random programs with random side inputs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = instr_aleatoria();
            aplica_reset();
            for (int c = 0; c < 250; c++)
                ciclo($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_busca.md
Name: controle_busca

Overview:
- Fetch/sequencing controller for the processor's 64-word instruction memory.
- Owns the PC and drives the memory address. Latches the returned 32-bit instruction into an instruction register.
- Resolves control flow: sequential, jump, jal, beq. Stalls on `in` until the user confirms. Issues per-instruction write/output strobes to the datapath.
- Sits between the instruction memory and the register file/ALU.

Parameters:
- TAM_MEM, 64: instruction memory depth in words. Legal PC range is 0..TAM_MEM-1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start strobe; sampled only in OCIOSO and PARADO
- Instrucao  in  32  instruction word read combinationally from memory at Endereco
- igual  in  1  datapath comparator result for ir rs/rt fields ([17:9]==[8:0] registers)
- entrada_ok  in  1  user confirm strobe for `in`
- Endereco  out  32  registered PC, zero-extended
- ir  out  32  registered instruction
- pc_mais_um  out  32  Endereco+1; link value for jal
- escreve_reg  out  1  register-file write enable, combinational from state/ir
- escreve_mem  out  1  data-memory write enable (str)
- saida_valida  out  1  one-cycle strobe for `out`
- esperando_entrada  out  1  high in ESPERA_ENTRADA
- parado  out  1  high in PARADO
- erro  out  1  sticky; set on illegal opcode or out-of-range PC
- estado  out  3  OCIOSO=0, BUSCA=1, EXECUTA=2, ESPERA_ENTRADA=3, PARADO=4

Behaviour:
- Reset (asynchronous, any state, including mid-instruction or mid-wait):
  - Enters OCIOSO. pc=0, ir=0, erro=0.
  - All strobes 0. parado=0, esperando_entrada=0.
- OCIOSO:
  - Stays here until iniciar=1, then goes to BUSCA.
  - The mandatory wait of at least one cycle after reset lets memory contents initialise before the first fetch.
- BUSCA: ir<=Instrucao. Go to EXECUTA. No strobes are asserted.
- EXECUTA decodes op=ir[31:27]:
  - 00000-01111 except 00110 (ALU/li/logic/compare): escreve_reg=1; pc<=pc+1.
  - 00110 str: escreve_mem=1; pc<=pc+1.
  - 10001 ld: escreve_reg=1; pc<=pc+1.
  - 10000 nop: pc<=pc+1.
  - 10010 jump: pc<=ir[26:18].
  - 10011 jal: escreve_reg=1 (datapath writes pc_mais_um into reg ir[26:18]); pc<=ir[17:9].
  - 10101 beq: pc<=ir[26:18] if igual=1, else pc+1.
  - 10111 out: saida_valida=1; pc<=pc+1.
  - 10110 in: pc unchanged; go to ESPERA_ENTRADA.
  - 10100 and 11000-11111: illegal. erro<=1; go to PARADO; pc unchanged.
  - All other legal cases return to BUSCA.
- Range check: if the computed next PC is >= TAM_MEM (sequential wrap or jump/beq target), erro<=1 and go to PARADO. The PC is not updated. The strobe of the current instruction still fires in that cycle.
- ESPERA_ENTRADA:
  - esperando_entrada=1.
  - On entrada_ok=1: escreve_reg=1 in that same cycle; pc<=pc+1 (range-checked as above); go to BUSCA.
  - Otherwise hold indefinitely.
- PARADO:
  - parado=1.
  - iniciar=1 restarts: pc<=0, erro<=0, go to BUSCA.
- Timing and ignored inputs:
  - Throughput is 2 cycles per non-`in` instruction.
  - iniciar in BUSCA, EXECUTA or ESPERA_ENTRADA is ignored.
  - entrada_ok outside ESPERA_ENTRADA is ignored.
  - igual is ignored except in EXECUTA with op=10101.
- Simultaneous events: async reset dominates everything. In PARADO with iniciar=1 the restart wins, and erro clears the same edge.
- Jump to self (e.g. jump 18 at address 18) is a legal infinite loop, not a halt.
- Strobes are asserted only in EXECUTA or ESPERA_ENTRADA, never in BUSCA.

Test Plan:
1. Reset low, then high, then iniciar pulse; program nop@0, nop@1:
   - Endereco 0 -> 1 -> 2 at 2-cycle spacing.
   - estado sequence 0,1,2,1,2,1.
   - No strobes.
2. li@0, add@1, out@2:
   - escreve_reg high exactly in the EXECUTA cycles of addresses 0 and 1.
   - saida_valida a single-cycle pulse at address 2; Endereco then 3.
3. beq target 10 @2:
   - igual=0 -> next Endereco 3.
   - Rerun with igual=1 -> next Endereco 10.
   - jump 2 @9 -> Endereco 2.
   - jal $18,33 @31 -> escreve_reg=1, pc_mais_um=32, then Endereco 33.
4. in @5:
   - estado=3, Endereco held at 5 for 20 cycles with entrada_ok=0.
   - entrada_ok pulse -> escreve_reg=1 that cycle, then Endereco 6.
   - Reset asserted during the wait -> estado 0, Endereco 0 immediately (asynchronous).
5. Illegal opcode 11111 @4:
   - estado 4, parado=1, erro=1, Endereco stays 4.
   - iniciar -> Endereco 0, erro=0, estado 1.
6. TAM_MEM=64 with nop@63 or jump 100:
   - PARADO with erro=1; Endereco stays 63 / the jump's address.
